// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and widths for the register-file writeback arbiter
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // One queued long-latency result: destination register and value
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } rf_wr_t;

  // One-hot mask selecting a register's pending bit
  function automatic logic [31:0] addr_mask(input logic [REG_ADDR_W-1:0] a);
    return 32'd1 << a;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// rtl/rf_arb_fifo.sv - small result FIFO holding long-latency writebacks
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  rf_wr_t push_data,
  input  logic   pop,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  rf_wr_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Storage needs no reset: the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares one register-file write port between the pipeline and long-latency results
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  output logic        wb_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wa,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int           SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic          grant_a;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  rf_wr_t        head;
  rf_wr_t        push_data;

  assign push_data.wa = lu_wa;
  assign push_data.wd = lu_wd;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Write-port grant: pipeline first, FIFO head when the pipeline is idle or forced to stall
  always_comb begin
    wb_stall = 1'b0;
    grant_a  = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    lu_ready = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    if (reset) begin
      wb_stall = wb_we && !empty && (starve_cnt == STARVE_MAX);
      grant_a  = wb_we && !wb_stall;
      pop      = !grant_a && !empty;
      if (grant_a) begin
        rf_we = 1'b1;
        rf_wa = wb_wa;
        rf_wd = wb_wd;
      end else if (pop) begin
        rf_we = 1'b1;
        rf_wa = head.wa;
        rf_wd = head.wd;
      end
      // A full FIFO still accepts when its head leaves this cycle
      lu_ready = !full || pop;
      push     = lu_valid && lu_ready;
    end
  end

  // Pending scoreboard update: clear the written head first so a same-cycle issue wins
  always_comb begin
    pending_next = pending;
    if (pop) begin
      pending_next = pending_next & ~addr_mask(head.wa);
    end
    if (iss_valid) begin
      pending_next = pending_next | addr_mask(iss_wa);
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard and starvation counter state
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending    <= '0;
      starve_cnt <= '0;
    end else begin
      pending <= pending_next;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (grant_a && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  assign busy1 = reset && pending[ra1] && (ra1 != 5'd0);
  assign busy2 = reset && pending[ra2] && (ra2 != 5'd0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_vec = 0;
  int n_err = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .wb_stall  (wb_stall),
    .lu_valid  (lu_valid),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .lu_ready  (lu_ready),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (busy1),
    .busy2     (busy2),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result queue, pending set, starvation count
  rf_wr_t      mq[$];
  bit   [31:0] mpend;
  int          mstarve;
  logic        e_we, e_stall, e_ready, e_b1, e_b2;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  bit          m_pop, m_push;

  task automatic model_eval();
    e_we = 0; e_wa = '0; e_wd = '0; e_stall = 0; e_ready = 0; e_b1 = 0; e_b2 = 0;
    m_pop = 0; m_push = 0;
    if (reset) begin
      e_stall = wb_we && (mq.size() > 0) && (mstarve == STARVE_LIMIT);
      if (wb_we && !e_stall) begin
        e_we = 1; e_wa = wb_wa; e_wd = wb_wd;
      end else if (mq.size() > 0) begin
        m_pop = 1; e_we = 1; e_wa = mq[0].wa; e_wd = mq[0].wd;
      end
      e_ready = (mq.size() < DEPTH) || m_pop;
      m_push  = lu_valid && e_ready;
      e_b1 = mpend[ra1] && (ra1 != 0);
      e_b2 = mpend[ra2] && (ra2 != 0);
    end
  endtask

  task automatic model_commit();
    rf_wr_t ent;
    bit     had;
    if (!reset) begin
      mq.delete(); mpend = '0; mstarve = 0;
    end else begin
      had = (mq.size() > 0);
      if (m_pop) begin
        mpend[mq[0].wa] = 1'b0;
        ent = mq.pop_front();
      end
      if (m_push) begin
        ent.wa = lu_wa; ent.wd = lu_wd;
        mq.push_back(ent);
      end
      if (iss_valid && iss_wa != 0) mpend[iss_wa] = 1'b1;
      if (!had || m_pop) mstarve = 0;
      else if (wb_we && !e_stall && mstarve < STARVE_LIMIT) mstarve++;
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic iv, input logic [4:0] iwa,
                       input logic [4:0] r1, input logic [4:0] r2);
    wb_we = we; wb_wa = wa; wb_wd = wd;
    lu_valid = lv; lu_wa = lwa; lu_wd = lwd;
    iss_valid = iv; iss_wa = iwa; ra1 = r1; ra2 = r2;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'd3, $urandom, 1, 5'd4, $urandom, 1, 5'd4, 5'd3, 5'd4);
      settle();
      n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
      n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL rst_lu_ready: got %b want 0", lu_ready); end
      n_vec++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rst_wb_stall: got %b want 0", wb_stall); end
      n_vec++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b%b want 00", busy1, busy2); end
      advance();
    end
    reset = 1'b1;
  endtask

  task automatic test_lu_latency();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL lat_busy_early: got %b want 0", busy1); end
    advance();
    drive(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 5'd5, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL lat_busy_set: got %b want 1", busy1); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL lat_bypass: got rf_we %b want 0", rf_we); end
    n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL lat_ready: got %b want 1", lu_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    settle();
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h1234})
      begin n_err++; $display("FAIL lat_write: got %b/%0d/%h want 1/5/1234", rf_we, rf_wa, rf_wd); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL lat_busy_hold: got %b want 1", busy1); end
    advance();
    settle();
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL lat_busy_clear: got %b want 0", busy1); end
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== 38'd0)
      begin n_err++; $display("FAIL lat_idle: got %b/%0d/%h want 0/0/0", rf_we, rf_wa, rf_wd); end
    advance();
  endtask

  task automatic test_priority();
    drive(1, 5'd3, 32'hA, 1, 5'd7, 32'hB, 0, 0, 0, 0);
    settle();
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'hA})
      begin n_err++; $display("FAIL pri_port_a: got %b/%0d/%h want 1/3/a", rf_we, rf_wa, rf_wd); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd7, 32'hB})
      begin n_err++; $display("FAIL pri_fifo: got %b/%0d/%h want 1/7/b", rf_we, rf_wa, rf_wd); end
    advance();
    settle();
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== 38'd0)
      begin n_err++; $display("FAIL pri_idle: got %b/%0d/%h want 0/0/0", rf_we, rf_wa, rf_wd); end
    advance();
  endtask

  task automatic test_starve();
    logic [4:0] exp_wa;
    for (int rep = 0; rep < 2; rep++) begin
      drive(1, 5'd1, $urandom, 1, 5'(8 + rep), 32'h500 + rep, 0, 0, 0, 0);
      settle();
      n_vec++; if (rf_wa !== 5'd1 || wb_stall !== 1'b0)
        begin n_err++; $display("FAIL starve_fill: got wa %0d stall %b want 1/0", rf_wa, wb_stall); end
      advance();
      for (int k = 1; k <= 6; k++) begin
        drive(1, 5'd2, k, 0, 0, 0, 0, 0, 0, 0);
        settle();
        exp_wa = (k == 5) ? 5'(8 + rep) : 5'd2;
        n_vec++; if (wb_stall !== (k == 5))
          begin n_err++; $display("FAIL starve_stall: rep %0d cycle %0d got %b want %b", rep, k, wb_stall, k == 5); end
        n_vec++; if (rf_we !== 1'b1 || rf_wa !== exp_wa)
          begin n_err++; $display("FAIL starve_wa: rep %0d cycle %0d got %b/%0d want 1/%0d", rep, k, rf_we, rf_wa, exp_wa); end
        advance();
      end
    end
  endtask

  task automatic test_full();
    drive(1, 5'd1, 32'h1, 1, 5'd10, 32'h100, 0, 0, 0, 0);
    settle();
    n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready0: got %b want 1", lu_ready); end
    advance();
    drive(1, 5'd1, 32'h1, 1, 5'd11, 32'h101, 0, 0, 0, 0);
    settle();
    n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %b want 1", lu_ready); end
    advance();
    for (int c = 2; c <= 5; c++) begin
      drive(1, 5'd1, 32'h1, 1, 5'd12, 32'h102, 0, 0, 0, 0);
      settle();
      n_vec++; if (lu_ready !== (c == 5))
        begin n_err++; $display("FAIL full_ready: cycle %0d got %b want %b", c, lu_ready, c == 5); end
      n_vec++; if (rf_wa !== ((c == 5) ? 5'd10 : 5'd1))
        begin n_err++; $display("FAIL full_head: cycle %0d got %0d want %0d", c, rf_wa, (c == 5) ? 10 : 1); end
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      n_vec++; if ({rf_we, rf_wa} !== ((c == 2) ? 6'd0 : {1'b1, 5'(11 + c)}))
        begin n_err++; $display("FAIL full_order: step %0d got %b/%0d want %0d", c, rf_we, rf_wa, (c == 2) ? 0 : 11 + c); end
      advance();
    end
  endtask

  task automatic test_iss_collision();
    drive(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL iss_busy0: got %b want 0", busy1); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    settle();
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h99})
      begin n_err++; $display("FAIL iss_write: got %b/%0d/%h want 1/9/99", rf_we, rf_wa, rf_wd); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL iss_busy1: got %b want 1", busy1); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL iss_set_wins: got %b want 1", busy1); end
    advance();
    drive(0, 0, 0, 1, 5'd9, 32'h98, 1, 5'd0, 5'd0, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL iss_r0: got %b%b want 00", busy1, busy2); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b1 || busy2 !== 1'b0 || rf_wa !== 5'd9)
      begin n_err++; $display("FAIL iss_drain: got busy %b%b wa %0d want 10/9", busy1, busy2, rf_wa); end
    advance();
    drive(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    settle();
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL iss_clear: got %b want 0", busy1); end
    n_vec++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd0, 32'hDEAD})
      begin n_err++; $display("FAIL iss_r0_write: got %b/%0d/%h want 1/0/dead", rf_we, rf_wa, rf_wd); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1, 5'd1, 32'h1, 1, 5'd20, 32'h200, 1, 5'd20, 5'd20, 5'd21);
    settle(); advance();
    drive(1, 5'd1, 32'h1, 1, 5'd21, 32'h201, 1, 5'd21, 5'd20, 5'd21);
    settle(); advance();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
    settle();
    n_vec++; if ({rf_we, lu_ready, wb_stall, busy1, busy2} !== 5'b0)
      begin n_err++; $display("FAIL mid_forced: got we/rdy/stall/b1/b2 %b%b%b%b%b want 00000", rf_we, lu_ready, wb_stall, busy1, busy2); end
    advance();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_vec++; if ({rf_we, lu_ready, busy1, busy2} !== 4'b0100)
        begin n_err++; $display("FAIL mid_after: cycle %0d got we/rdy/b1/b2 %b%b%b%b want 0100", c, rf_we, lu_ready, busy1, busy2); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 79) != 0);
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle();
      n_vec++; if (rf_we !== e_we) begin n_err++; $display("FAIL rnd_rf_we: cycle %0d got %b want %b", c, rf_we, e_we); end
      n_vec++; if (rf_wa !== e_wa) begin n_err++; $display("FAIL rnd_rf_wa: cycle %0d got %0d want %0d", c, rf_wa, e_wa); end
      n_vec++; if (rf_wd !== e_wd) begin n_err++; $display("FAIL rnd_rf_wd: cycle %0d got %h want %h", c, rf_wd, e_wd); end
      n_vec++; if (wb_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall: cycle %0d got %b want %b", c, wb_stall, e_stall); end
      n_vec++; if (lu_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, lu_ready, e_ready); end
      n_vec++; if (busy1 !== e_b1) begin n_err++; $display("FAIL rnd_busy1: cycle %0d got %b want %b", c, busy1, e_b1); end
      n_vec++; if (busy2 !== e_b2) begin n_err++; $display("FAIL rnd_busy2: cycle %0d got %b want %b", c, busy2, e_b2); end
      advance();
    end
    reset = 1'b1;
  endtask

  initial begin
    mpend = '0; mstarve = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_lu_latency();
    test_priority();
    test_starve();
    test_full();
    test_iss_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
